// File: rtl/symbol_demodulator.sv
// Integrate-and-dump symbol demodulator: sums SPS signed samples per symbol and
// makes a BPSK sign or ASK threshold decision, with a one-deep valid/ready output.
module symbol_demodulator #(
    parameter int DATA_W = 16,
    parameter int SPS    = 8,
    parameter int MODE   = 0,
    localparam int ACC_W = DATA_W + $clog2(SPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    input  logic                     sync,
    input  logic signed [ACC_W-1:0]  threshold,
    output logic                     sym_valid,
    input  logic                     sym_ready,
    output logic                     sym_bit,
    output logic signed [ACC_W-1:0]  sym_energy
);

    localparam int CNT_W = $clog2(SPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sym_valid_q, sym_valid_d;
    logic                    sym_bit_q, sym_bit_d;
    logic signed [ACC_W-1:0] energy_q, energy_d;

    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    last;
    logic                    accept;
    logic                    complete;
    logic                    decision;

    // ACC_W leaves clog2(SPS) headroom bits, so a full symbol can never wrap.
    assign sample_ext = ACC_W'(in_data);
    assign sum        = acc_q + sample_ext;
    assign last       = (cnt_q == CNT_LAST);
    assign in_ready   = !(last && sym_valid_q && !sym_ready);
    assign accept     = in_valid && in_ready;
    assign complete   = accept && last && !sync;
    assign decision   = (MODE == 0) ? !sum[ACC_W-1] : (sum > threshold);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sym_valid_d = sym_valid_q;
        sym_bit_d   = sym_bit_q;
        energy_d    = energy_q;

        if (sync) begin
            acc_d = accept ? sample_ext : '0;
            cnt_d = accept ? CNT_W'(1) : '0;
        end else if (accept) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A completing sample is only accepted when the output slot is free or draining now.
        if (complete) begin
            sym_valid_d = 1'b1;
            sym_bit_d   = decision;
            energy_d    = sum;
        end else if (sym_valid_q && sym_ready) begin
            sym_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_bit_q   <= 1'b0;
            energy_q    <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sym_valid_q <= sym_valid_d;
            sym_bit_q   <= sym_bit_d;
            energy_q    <= energy_d;
        end
    end

    assign sym_valid  = sym_valid_q;
    assign sym_bit    = sym_bit_q;
    assign sym_energy = energy_q;

endmodule

// File: tb/tb_symbol_demodulator.sv
// Self-checking bench for symbol_demodulator: directed spec scenarios plus random
// traffic, checked against a queue-based symbol model, on BPSK and ASK instances.
module tb_symbol_demodulator;

    localparam int DATA_W = 16;
    localparam int SPS    = 4;
    localparam int ACC_W  = 18;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     sync;
    logic signed [ACC_W-1:0]  threshold;
    logic                     sym_ready;

    logic                     in_ready_b, sym_valid_b, sym_bit_b;
    logic signed [ACC_W-1:0]  sym_energy_b;
    logic                     in_ready_a, sym_valid_a, sym_bit_a;
    logic signed [ACC_W-1:0]  sym_energy_a;

    int vectors   = 0;
    int miscompares = 0;

    // Behavioural model: samples of the symbol in progress plus the held output symbol.
    int partial[$];
    bit m_valid;
    int m_energy;
    bit m_bit_b, m_bit_a;
    bit last_ready;

    symbol_demodulator #(.DATA_W(DATA_W), .SPS(SPS), .MODE(0)) dut_bpsk (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
        .sync(sync), .threshold(threshold), .sym_valid(sym_valid_b), .sym_ready(sym_ready),
        .sym_bit(sym_bit_b), .sym_energy(sym_energy_b)
    );

    symbol_demodulator #(.DATA_W(DATA_W), .SPS(SPS), .MODE(1)) dut_ask (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
        .sync(sync), .threshold(threshold), .sym_valid(sym_valid_a), .sym_ready(sym_ready),
        .sym_bit(sym_bit_a), .sym_energy(sym_energy_a)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input bit r);
        return !(partial.size() == SPS - 1 && m_valid && !r);
    endfunction

    task automatic model_reset();
        partial.delete();
        m_valid  = 1'b0;
        m_energy = 0;
        m_bit_b  = 1'b0;
        m_bit_a  = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int d, input bit s, input bit r, input int thr);
        bit acc_ok;
        bit done;
        int total;
        acc_ok = v && model_ready(r);
        done   = 1'b0;
        total  = 0;
        if (s) begin
            partial.delete();
            if (acc_ok) partial.push_back(d);
        end else if (acc_ok) begin
            partial.push_back(d);
            if (partial.size() == SPS) begin
                foreach (partial[i]) total += partial[i];
                partial.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            m_valid  = 1'b1;
            m_energy = total;
            m_bit_b  = (total >= 0);
            m_bit_a  = (total > thr);
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_model();
        chk("in_ready_bpsk", in_ready_b, model_ready(sym_ready));
        chk("in_ready_ask", in_ready_a, model_ready(sym_ready));
        chk("sym_valid_bpsk", sym_valid_b, m_valid);
        chk("sym_valid_ask", sym_valid_a, m_valid);
        if (m_valid) begin
            chk("energy_bpsk", sym_energy_b, m_energy);
            chk("energy_ask", sym_energy_a, m_energy);
            chk("bit_bpsk", sym_bit_b, m_bit_b);
            chk("bit_ask", sym_bit_a, m_bit_a);
        end
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model on the rising edge.
    task automatic step(input bit v, input logic [15:0] d, input bit s, input bit r);
        in_valid  = v;
        in_data   = d;
        sync      = s;
        sym_ready = r;
        @(negedge clk);
        compare_model();
        last_ready = in_ready_b;
        @(posedge clk);
        model_edge(v, $signed(d), s, r, $signed(threshold));
        #1;
    endtask

    task automatic feed(input int n, input logic [15:0] d, input bit r);
        for (int i = 0; i < n; i++) step(1'b1, d, 1'b0, r);
    endtask

    task automatic expect_sym(input string tag, input int energy, input bit b, input bit ask);
        chk({tag, "_valid"}, sym_valid_b, 1'b1);
        chk({tag, "_energy"}, sym_energy_b, energy);
        if (ask) chk({tag, "_bit"}, sym_bit_a, b);
        else     chk({tag, "_bit"}, sym_bit_b, b);
    endtask

    task automatic drain();
        step(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        sync      = 1'b0;
        sym_ready = 1'b1;
        threshold = 18'sd500;
        model_reset();
        #1;
        chk("rst_valid", sym_valid_b, 1'b0);
        chk("rst_energy", sym_energy_b, 32'h0);
        chk("rst_bit", sym_bit_b, 1'b0);
        chk("rst_ready", in_ready_b, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;

        // BPSK sign decisions
        feed(4, 16'h0100, 1'b1);
        expect_sym("bpsk_pos", 1024, 1'b1, 1'b0);
        feed(4, 16'hFF00, 1'b1);
        expect_sym("bpsk_neg", -1024, 1'b0, 1'b0);
        drain();

        // ASK threshold decisions at level 500
        feed(4, 16'd100, 1'b1);
        expect_sym("ask_400", 400, 1'b0, 1'b1);
        feed(4, 16'd200, 1'b1);
        expect_sym("ask_800", 800, 1'b1, 1'b1);
        feed(4, 16'd125, 1'b1);
        expect_sym("ask_500", 500, 1'b0, 1'b1);
        drain();

        // Backpressure: eighth sample stalls until the held symbol drains
        feed(4, 16'd10, 1'b0);
        expect_sym("bp_first", 40, 1'b1, 1'b0);
        feed(3, 16'd20, 1'b0);
        step(1'b1, 16'd20, 1'b0, 1'b0);
        chk("bp_ready8", last_ready, 1'b0);
        expect_sym("bp_held", 40, 1'b1, 1'b0);
        step(1'b1, 16'd20, 1'b0, 1'b1);
        chk("bp_ready8_go", last_ready, 1'b1);
        expect_sym("bp_second", 80, 1'b1, 1'b0);
        drain();
        chk("bp_drained", sym_valid_b, 1'b0);

        // Sync discards the partial symbol
        feed(2, 16'h7FFF, 1'b1);
        step(1'b1, 16'hFFF0, 1'b1, 1'b1);
        feed(2, 16'hFFF0, 1'b1);
        chk("sync_no_sym", sym_valid_b, 1'b0);
        feed(1, 16'hFFF0, 1'b1);
        expect_sym("sync_sym", -64, 1'b0, 1'b0);
        drain();

        // Full-scale extremes
        feed(4, 16'h8000, 1'b1);
        expect_sym("ext_neg", -131072, 1'b0, 1'b0);
        feed(4, 16'h7FFF, 1'b1);
        expect_sym("ext_pos", 131068, 1'b1, 1'b0);
        drain();

        // Asynchronous reset mid-symbol with a held output
        feed(4, 16'd7, 1'b0);
        feed(2, 16'd9, 1'b0);
        chk("mid_held", sym_valid_b, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", sym_valid_b, 1'b0);
        chk("mid_rst_energy", sym_energy_b, 32'h0);
        chk("mid_rst_ready", in_ready_b, 1'b1);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        feed(3, 16'd5, 1'b1);
        chk("mid_fresh_pending", sym_valid_b, 1'b0);
        feed(1, 16'd5, 1'b1);
        expect_sym("mid_fresh", 20, 1'b1, 1'b0);
        drain();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] d;
            case ($urandom_range(0, 7))
                0:       d = 16'h8000;
                1:       d = 16'h7FFF;
                2:       d = 16'($urandom_range(0, 255)) - 16'd128;
                default: d = 16'($urandom);
            endcase
            if ($urandom_range(0, 99) == 0) threshold = 18'($urandom);
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
